// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and default bit period.
// The default bit period is 48 MHz / 38400 baud and is intended to be shared with a transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 1250;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchronizer for asynchronous inputs.
// All stages reset to RST_VAL so a quiet line stays quiet through reset.
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, start-glitch rejection and break handling.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  output logic                      frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                      parity_err,
`endif
  output logic                      busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

  logic rxs;

  sync_ff #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rxs)
  );

  uart_rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      ferr_q, ferr_d;
  logic                      tick;
  logic                      par_bad;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;

  // Even parity: data bits plus parity bit must XOR to zero.
  assign par_bad = ^{shift_q, par_q};
`else
  assign par_bad = 1'b0;
`endif

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          cnt_d   = HALF_BIT;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (!tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rxs) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = FULL_BIT;
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          shift_d = {rxs, shift_q[UART_DATA_BITS-1:1]};
          cnt_d   = FULL_BIT;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
      ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (!tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          par_d   = rxs;
          cnt_d   = FULL_BIT;
          state_d = ST_STOP;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Strobes are registered, so they appear the cycle after this sample.
          if (rxs && !par_bad) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
          ferr_d  = !rxs;
`ifdef UART_RX_PARITY_EN
          perr_d  = par_bad;
`endif
          state_d = rxs ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (rxs) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: builds a per-cycle line waveform, plays it, and compares every
// strobe against a model that samples the same waveform at the nominal bit centres.
module tb_uart_rx;

  localparam int C  = 16;
  localparam int SS = 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;
  logic       perr_w;

  uart_rx #(
    .CLKS_PER_BIT (C),
    .SYNC_STAGES  (SS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (perr_w),
`endif
    .busy       (busy)
  );

`ifndef UART_RX_PARITY_EN
  assign perr_w = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         v;
    bit         fe;
    bit         pe;
    logic [7:0] d;
  } evt_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         busy_cnt;
  bit         rec_en  = 1'b0;
  bit         wave[$];
  evt_t       got_q[$];
  evt_t       exp_q[$];
  evt_t       mon_e;
  logic [7:0] model_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rec_en) begin
      if (busy) busy_cnt++;
      if (valid || frame_err || perr_w) begin
        mon_e.cyc = cyc;
        mon_e.v   = valid;
        mon_e.fe  = frame_err;
        mon_e.pe  = perr_w;
        mon_e.d   = data;
        got_q.push_back(mon_e);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic add_level(input bit v, input int n);
    repeat (n) wave.push_back(v);
  endtask

  task automatic add_frame(input logic [7:0] b, input int p, input bit stop, input bit par_bad);
    add_level(1'b0, p);
    for (int k = 0; k < 8; k++) add_level(b[k], p);
    if (PAR) add_level((^b) ^ par_bad, p);
    add_level(stop, p);
  endtask

  // Receiver behaviour from the frame rules: a low level in idle opens a frame whose
  // start, data, parity and stop bits are read at half a bit plus whole bit periods.
  task automatic run_model(input int from, input int base);
    int         n;
    int         i;
    int         j;
    int         h;
    int         st;
    bit         pbad;
    bit         stopb;
    logic [7:0] b;
    evt_t       e;
    n = wave.size();
    i = from;
    h = C / 2;
    while (i < n) begin
      if (wave[i]) begin
        i++;
      end else if (i + h >= n) begin
        i = n;
      end else if (wave[i + h]) begin
        i = i + h + 1;
      end else begin
        st = i + h + (9 + int'(PAR)) * C;
        if (st >= n) begin
          i = n;
        end else begin
          for (int k = 0; k < 8; k++) b[k] = wave[i + h + (k + 1) * C];
          pbad  = PAR ? ((^b) ^ wave[i + h + 9 * C]) : 1'b0;
          stopb = wave[st];
          if (stopb && !pbad) model_data = b;
          e.cyc = base + st + SS + 1;
          e.v   = stopb && !pbad;
          e.fe  = !stopb;
          e.pe  = pbad;
          e.d   = model_data;
          exp_q.push_back(e);
          if (stopb) begin
            i = st + 1;
          end else begin
            j = st + 1;
            while (j < n && !wave[j]) j++;
            i = j + 1;
          end
        end
      end
    end
  endtask

  task automatic play(input int rst_at, output int base);
    @(posedge clk); #1;
    base = cyc;
    for (int i = 0; i < wave.size(); i++) begin
      rx = wave[i];
      if (i == rst_at) rst = 1'b1;
      @(posedge clk); #1;
      if (i == rst_at) begin
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_data", data, 0);
        check("midrst_valid", valid, 0);
      end
    end
  endtask

  task automatic compare_events(input string tag);
    check({tag, "_nevt"}, got_q.size(), exp_q.size());
    for (int k = 0; k < got_q.size(); k++) begin
      $display("[TB] %s rx %0d cyc=%0d valid=%0b ferr=%0b perr=%0b data=%02h",
               tag, k, got_q[k].cyc, got_q[k].v, got_q[k].fe, got_q[k].pe, got_q[k].d);
      if (k < exp_q.size()) begin
        check({tag, "_cyc"}, got_q[k].cyc, exp_q[k].cyc);
        check({tag, "_valid"}, got_q[k].v, exp_q[k].v);
        check({tag, "_ferr"}, got_q[k].fe, exp_q[k].fe);
        check({tag, "_perr"}, got_q[k].pe, exp_q[k].pe);
        check({tag, "_data"}, got_q[k].d, exp_q[k].d);
      end
    end
  endtask

  task automatic run_scn(input string tag, input int rst_at);
    int base;
    got_q.delete();
    exp_q.delete();
    busy_cnt = 0;
    rec_en   = 1'b1;
    play(rst_at, base);
    rec_en   = 1'b0;
    if (rst_at >= 0) begin
      model_data = 8'h00;
      run_model(rst_at + 1, base);
    end else begin
      run_model(0, base);
    end
    compare_events(tag);
    wave.delete();
  endtask

  initial begin
    int p;
    bit stop;
    bit pb;

    repeat (3) @(posedge clk);
    #1;
    check("reset_data", data, 8'h00);
    check("reset_valid", valid, 0);
    check("reset_ferr", frame_err, 0);
    check("reset_perr", perr_w, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);

    // Back-to-back bytes.
    add_level(1'b1, 5);
    add_frame(8'h55, C, 1'b1, 1'b0);
    add_frame(8'hA5, C, 1'b1, 1'b0);
    add_level(1'b1, 200);
    run_scn("b2b", -1);

    // Short start glitch: busy for half a bit, no strobes.
    add_level(1'b1, 10);
    add_level(1'b0, 4);
    add_level(1'b1, 60);
    run_scn("glitch", -1);
    check("glitch_busy_cycles", busy_cnt, C / 2);

    // Framing error followed by a held-low line, then a good byte.
    add_level(1'b1, 5);
    add_frame(8'h3C, C, 1'b0, 1'b0);
    add_level(1'b0, 40);
    add_level(1'b1, 30);
    add_frame(8'h81, C, 1'b1, 1'b0);
    add_level(1'b1, 200);
    run_scn("break", -1);

    // Reset in the middle of data bit 4.
    add_frame(8'hFF, C, 1'b1, 1'b0);
    add_level(1'b1, 20);
    add_frame(8'h12, C, 1'b1, 1'b0);
    add_level(1'b1, 200);
    run_scn("midrst", 5 * C + 5);

    // Bit period off by one cycle either way.
    add_level(1'b1, 5);
    add_frame(8'hC3, C - 1, 1'b1, 1'b0);
    add_level(1'b1, 40);
    add_frame(8'hC3, C + 1, 1'b1, 1'b0);
    add_level(1'b1, 200);
    run_scn("baud", -1);

`ifdef UART_RX_PARITY_EN
    add_level(1'b1, 5);
    add_frame(8'h07, C, 1'b1, 1'b0);
    add_level(1'b1, 30);
    add_frame(8'h07, C, 1'b1, 1'b1);
    add_level(1'b1, 30);
    add_frame(8'h5A, C, 1'b0, 1'b1);
    add_level(1'b1, 200);
    run_scn("parity", -1);
`endif

    // Random traffic: rate skew, bad stop bits, held-low lines and glitches.
    for (int r = 0; r < 4; r++) begin
      add_level(1'b1, 5);
      for (int f = 0; f < 8; f++) begin
        p    = $urandom_range(C - 1, C + 1);
        stop = ($urandom_range(0, 9) != 0);
        pb   = PAR && ($urandom_range(0, 4) == 0);
        add_frame(8'($urandom), p, stop, pb);
        if (!stop) add_level(1'b0, $urandom_range(0, 30));
        add_level(1'b1, $urandom_range(0, 20));
        if ($urandom_range(0, 3) == 0) begin
          add_level(1'b0, $urandom_range(1, C / 2 - 1));
          add_level(1'b1, C);
        end
      end
      add_level(1'b1, 200);
      run_scn("rand", -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Synchronous 8N1 UART receiver that replaces the ripple-clocked serial input stage feeding the 4-digit hex display. Runs entirely on the 48 MHz system clock. Uses a per-bit tick counter instead of a divided clock, with mid-bit sampling and start-bit glitch rejection. Produces a one-cycle `valid` strobe with the received byte, so the display data register loads synchronously on `valid` rather than on a derived edge.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 1250: system clocks per bit (48 000 000 / 38 400). Legal values are ≥ 4.
- `SYNC_STAGES`, default 2: flip-flop stages on `rx`. Legal values are ≥ 2.

Ports:
- `clk` input 1: system clock, 48 MHz.
- `rst` input 1: reset, synchronous, active-high.
- `rx` input 1: serial line, asynchronous, idle high.
- `data` output 8: last good byte. Holds its value until the next good byte.
- `valid` output 1: one-cycle strobe when `data` is updated.
- `frame_err` output 1: one-cycle strobe when the stop bit samples 0.
- `busy` output 1: high whenever the state is not IDLE.
- `parity_err` output 1: one-cycle strobe on parity mismatch. Present only with `UART_RX_PARITY_EN`.

## Operation
- `rx` passes through `SYNC_STAGES` flip-flops. All logic uses the synchronized value `rxs`.
- States: IDLE, START, DATA, (PARITY), STOP, BREAK.
- **IDLE:** on `rxs` = 0, load tick counter with `CLKS_PER_BIT/2 - 1` (integer division) and go to START.
- **START:** when the counter reaches 0, sample `rxs`.
  - If 1, the start was a glitch: go to IDLE with no strobe.
  - If 0, load counter `CLKS_PER_BIT - 1`, clear bit index, go to DATA.
- **DATA:** at each counter zero, shift `rxs` into the shift register MSB, shifting right (LSB first on the wire).
  - Reload counter `CLKS_PER_BIT - 1` and increment the 3-bit index.
  - After index 7, go to STOP (or PARITY when the macro is defined).
- **STOP:** at counter zero, sample `rxs`.
  - If 1: `data` takes the shift register, pulse `valid`, go to IDLE. A new start edge can be detected from the next cycle, half a bit before the nominal end of the stop bit.
  - If 0: pulse `frame_err`, leave `data` unchanged, go to BREAK.
- **BREAK:** stay until `rxs` = 1, then go to IDLE. This prevents a held-low line from being decoded as repeated 0x00 bytes.
- `valid` and `frame_err` are never high in the same cycle.
- Reset in any state, including mid-byte: next state is IDLE. A partially received byte is discarded.

## Timing
- Reset values:
  - `data` = 8'h00; `valid`, `frame_err`, `parity_err`, `busy` = 0.
  - Synchronizer flip-flops = 1, so no false start after reset.
  - Counter and index = 0.
- Let cycle 0 be the first `clk` edge at which `rxs` is seen low in IDLE.
  - Data bit k is sampled at cycle `CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT`.
  - The stop bit is sampled at cycle `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT`.
- `valid` / `frame_err` are registered: high for exactly the one cycle after the stop sample.
- `data` changes on the same edge that `valid` rises.
- Pin-to-`rxs` latency is `SYNC_STAGES` cycles.
- No backpressure: a consumer that misses `valid` loses the byte. Bytes arrive at most once per 10 bit times.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Format is 8E1. A PARITY state sits between DATA and STOP and samples one extra bit.
  - If the XOR of the 8 data bits and the parity bit is 1, pulse `parity_err` together with the stop-sample strobe cycle and suppress `valid`. `data` is unchanged.
  - A bad stop bit still reports `frame_err` (both strobes may assert together).
  - The stop bit is sampled at `CLKS_PER_BIT/2 + 10*CLKS_PER_BIT`.
- Undefined: format is 8N1, there is no PARITY state, and the `parity_err` port does not exist.

## Structure
- Package `uart_pkg` holds:
  - the state enum `uart_rx_state_t`;
  - constant `UART_DATA_BITS = 8`;
  - default `CLKS_PER_BIT = 1250`, shared with a future `uart_tx`.
- Sub-module `sync_ff`: parameterized N-stage synchronizer with reset value parameter; used for `rx`.
- Tick counter width is `$clog2(CLKS_PER_BIT)`.

## Test plan
Benches use `CLKS_PER_BIT = 16`, `SYNC_STAGES = 2`.
1. Send 0x55, then 0xA5, back-to-back with 1 stop bit → `valid` pulses twice, each exactly one cycle; `data` = 8'h55, then 8'hA5; `frame_err` stays 0.
2. Drive `rx` low for 4 cycles from idle → return to IDLE; no `valid`, no `frame_err`; `busy` drops 8 cycles after entry.
3. Send 0x3C with stop bit = 0, then hold `rx` low for 40 cycles, then release → one `frame_err` pulse; `data` keeps its previous value; no further strobes until a new byte 0x81 is received → `data` = 8'h81.
4. Assert `rst` for 1 cycle during data bit 4 of 0xFF, then send 0x12 → no `valid` for 0xFF; `data` = 8'h12 after the second frame.
5. Baud mismatch: bit period 15 and 17 cycles with byte 0xC3 → `data` = 8'hC3 in both cases.
6. With `UART_RX_PARITY_EN`: send 0x07 with parity 1 → `valid`, `data` = 8'h07. Send 0x07 with parity 0 → `parity_err` pulses, no `valid`.
